alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Integer execute stage directly downstream of the ALU reservation station.
//  - Takes one ready op per cycle: opcode, pc, both operand values, imm, ROB id.
//  - Computes the result, branch decision and target in one cycle.
//  - Queues results in a small in-order result FIFO.
//  - Presents the FIFO head on the common data bus (CDB) toward ROB/RS/LSB; CDB arbiter grants the bus.
// PARAMETERS
//  FIFO_DEPTH    4   result FIFO entries (power of 2, >=2)
//  DATA_WIDTH    32  operand/result/pc width
//  ROB_ID_WIDTH  4   ROB tag width (matches `ROBIDBus)
//  OP_WIDTH      6   op id width (matches `OpIdBus)
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   async reset, active-high
//  rdy                 in   1   global enable; 0 freezes all state
//  ROB_roll_back_flag  in   1   mispredict flush
//  RS_input_valid      in   1   op valid from RS
//  RS_OP_ID            in   6   op id (`defines op codes)
//  RS_inst_pc          in   32  instruction pc
//  RS_reg_rs1          in   32  operand 1
//  RS_reg_rs2          in   32  operand 2
//  RS_imm              in   32  sign-extended immediate
//  RS_ROB_id           in   4   destination ROB tag
//  RS_ALU_is_full      out  1   back-pressure to RS
//  CDB_grant           in   1   arbiter accepts head this cycle
//  CDB_valid           out  1   head entry valid
//  CDB_ROB_id          out  4   head ROB tag
//  CDB_value           out  32  rd write value
//  CDB_jump_flag       out  1   control transfer taken
//  CDB_target_pc       out  32  resolved next pc (branch/JAL/JALR)
// BEHAVIOUR
//  - Reset (async): FIFO empty, count=0, ptrs=0, all CDB_* = 0, RS_ALU_is_full=0.
//  - Push: RS_input_valid && rdy && !roll_back -> compute, write at tail.
//    Latency 1: result visible on CDB the cycle after acceptance.
//  - Pop: CDB_valid && CDB_grant && rdy -> head advances.
//    Push+pop in the same cycle -> count unchanged.
//  - Pointers wrap modulo FIFO_DEPTH. CDB_* are registered head fields; all 0 when empty.
//  - RS_ALU_is_full = (count >= FIFO_DEPTH-1). The spare slot absorbs the op RS issued from
//    its output register the cycle before.
//  - Push when count==FIFO_DEPTH is a protocol violation: input dropped, state untouched.
//  - ROB_roll_back_flag (rdy=1): next edge empties FIFO, CDB_valid=0, same-cycle input ignored.
//  - rdy=0: no push, no pop, no flush; outputs hold.
//  - Arithmetic: all ops mod 2^32.
//    Shifts use amount[4:0]; SRA/SRAI arithmetic.
//    SLT/SLTI signed, SLTU/SLTIU unsigned.
//  - I-type ops use RS_imm in place of rs2.
//  - LUI: value = imm.
//  - AUIPC: value = pc+imm.
//  - JAL: value = pc+4, target = pc+imm, jump=1.
//  - JALR: value = pc+4, target = (rs1+imm)&~1, jump=1.
//  - Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU): value = 0, jump = cond,
//    target = cond ? pc+imm : pc+4.
//  - Non-branch, non-jump ops: jump=0, target=pc+4.
//  - Any op id outside this set: value 0, jump 0, target pc+4, still retired via CDB.
// CONFIGURATION
//  ALU_PERF_CNT_EN defined:
//    - adds outputs perf_ops_done (32) and perf_jumps_taken (32);
//    - +1 per pop, and per pop with jump=1;
//    - cleared by rst only (not by roll back); wrap at 2^32.
//  ALU_PERF_CNT_EN undefined: ports and counters absent; other behaviour identical.
// TESTING
//  1. ADD rs1=5 rs2=7 id=3, grant=1 -> next cycle CDB_valid=1 id=3 value=12;
//     cycle after CDB_valid=0.
//  2. SRAI rs1=0xFFFFFFF8 imm=1 -> value 0xFFFFFFFC;
//     SLTU rs1=0xFFFFFFFF rs2=1 -> value 0.
//  3. BNE pc=0x100 rs1=1 rs2=2 imm=0x20 -> jump=1 target=0x120;
//     BEQ same operands -> jump=0 target=0x104.
//  4. JALR pc=0x40 rs1=0x1001 imm=4 -> value=0x44 target=0x1004 jump=1.
//  5. grant=0, push ids 1,2,3 -> RS_ALU_is_full=1 once count=3;
//     grant=1 -> ids 1,2,3 pop in order, is_full drops when count<3.
//  6. Two entries queued plus input valid, roll back=1 -> next cycle CDB_valid=0, is_full=0;
//     async rst mid-stream -> all outputs 0 before next edge.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Integer execute stage: one-cycle ALU/branch resolve feeding an in-order result FIFO whose head drives the CDB.
// Optional macro ALU_PERF_CNT_EN adds retired-op and taken-jump counters.
module alu_exec_unit #(
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = 4,
  parameter int OP_WIDTH     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    ROB_roll_back_flag,
  input  logic                    RS_input_valid,
  input  logic [OP_WIDTH-1:0]     RS_OP_ID,
  input  logic [DATA_WIDTH-1:0]   RS_inst_pc,
  input  logic [DATA_WIDTH-1:0]   RS_reg_rs1,
  input  logic [DATA_WIDTH-1:0]   RS_reg_rs2,
  input  logic [DATA_WIDTH-1:0]   RS_imm,
  input  logic [ROB_ID_WIDTH-1:0] RS_ROB_id,
  output logic                    RS_ALU_is_full,
  input  logic                    CDB_grant,
  output logic                    CDB_valid,
  output logic [ROB_ID_WIDTH-1:0] CDB_ROB_id,
  output logic [DATA_WIDTH-1:0]   CDB_value,
  output logic                    CDB_jump_flag,
  output logic [DATA_WIDTH-1:0]   CDB_target_pc
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [31:0]             perf_ops_done,
  output logic [31:0]             perf_jumps_taken
`endif
);

  // Handshake: an op is taken on any edge where RS_input_valid && rdy && !ROB_roll_back_flag;
  // the head leaves on any edge where CDB_valid && CDB_grant && rdy. RS must stop issuing on RS_ALU_is_full.
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [OP_WIDTH-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_WIDTH-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_WIDTH-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_WIDTH-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_WIDTH-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_WIDTH-1:0] OP_BLT   = 6'd7;
  localparam logic [OP_WIDTH-1:0] OP_BGE   = 6'd8;
  localparam logic [OP_WIDTH-1:0] OP_BLTU  = 6'd9;
  localparam logic [OP_WIDTH-1:0] OP_BGEU  = 6'd10;
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'd19;
  localparam logic [OP_WIDTH-1:0] OP_SLTI  = 6'd20;
  localparam logic [OP_WIDTH-1:0] OP_SLTIU = 6'd21;
  localparam logic [OP_WIDTH-1:0] OP_XORI  = 6'd22;
  localparam logic [OP_WIDTH-1:0] OP_ORI   = 6'd23;
  localparam logic [OP_WIDTH-1:0] OP_ANDI  = 6'd24;
  localparam logic [OP_WIDTH-1:0] OP_SLLI  = 6'd25;
  localparam logic [OP_WIDTH-1:0] OP_SRLI  = 6'd26;
  localparam logic [OP_WIDTH-1:0] OP_SRAI  = 6'd27;
  localparam logic [OP_WIDTH-1:0] OP_ADD   = 6'd28;
  localparam logic [OP_WIDTH-1:0] OP_SUB   = 6'd29;
  localparam logic [OP_WIDTH-1:0] OP_SLL   = 6'd30;
  localparam logic [OP_WIDTH-1:0] OP_SLT   = 6'd31;
  localparam logic [OP_WIDTH-1:0] OP_SLTU  = 6'd32;
  localparam logic [OP_WIDTH-1:0] OP_XOR   = 6'd33;
  localparam logic [OP_WIDTH-1:0] OP_SRL   = 6'd34;
  localparam logic [OP_WIDTH-1:0] OP_SRA   = 6'd35;
  localparam logic [OP_WIDTH-1:0] OP_OR    = 6'd36;
  localparam logic [OP_WIDTH-1:0] OP_AND   = 6'd37;

  logic [DATA_WIDTH-1:0] w_op2;
  logic [DATA_WIDTH-1:0] w_pc4;
  logic [DATA_WIDTH-1:0] w_pcimm;
  logic [DATA_WIDTH-1:0] w_jalr_sum;
  logic [DATA_WIDTH-1:0] w_value;
  logic [DATA_WIDTH-1:0] w_target;
  logic                  w_jump;
  logic                  w_is_br;
  logic                  w_br_cond;

  assign w_pc4      = RS_inst_pc + DATA_WIDTH'(4);
  assign w_pcimm    = RS_inst_pc + RS_imm;
  assign w_jalr_sum = RS_reg_rs1 + RS_imm;

  always_comb begin
    w_op2 = RS_reg_rs2;
    case (RS_OP_ID)
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
      OP_SLLI, OP_SRLI, OP_SRAI: w_op2 = RS_imm;
      default: w_op2 = RS_reg_rs2;
    endcase
  end

  always_comb begin
    w_value   = '0;
    w_jump    = 1'b0;
    w_target  = w_pc4;
    w_is_br   = 1'b0;
    w_br_cond = 1'b0;
    case (RS_OP_ID)
      OP_LUI:   w_value = RS_imm;
      OP_AUIPC: w_value = w_pcimm;
      OP_JAL: begin
        w_value  = w_pc4;
        w_target = w_pcimm;
        w_jump   = 1'b1;
      end
      OP_JALR: begin
        w_value  = w_pc4;
        w_target = w_jalr_sum & {{(DATA_WIDTH-1){1'b1}}, 1'b0};
        w_jump   = 1'b1;
      end
      OP_BEQ:  begin w_is_br = 1'b1; w_br_cond = (RS_reg_rs1 == RS_reg_rs2); end
      OP_BNE:  begin w_is_br = 1'b1; w_br_cond = (RS_reg_rs1 != RS_reg_rs2); end
      OP_BLT:  begin w_is_br = 1'b1; w_br_cond = ($signed(RS_reg_rs1) <  $signed(RS_reg_rs2)); end
      OP_BGE:  begin w_is_br = 1'b1; w_br_cond = ($signed(RS_reg_rs1) >= $signed(RS_reg_rs2)); end
      OP_BLTU: begin w_is_br = 1'b1; w_br_cond = (RS_reg_rs1 <  RS_reg_rs2); end
      OP_BGEU: begin w_is_br = 1'b1; w_br_cond = (RS_reg_rs1 >= RS_reg_rs2); end
      OP_ADD, OP_ADDI:   w_value = RS_reg_rs1 + w_op2;
      OP_SUB:            w_value = RS_reg_rs1 - w_op2;
      OP_XOR, OP_XORI:   w_value = RS_reg_rs1 ^ w_op2;
      OP_OR,  OP_ORI:    w_value = RS_reg_rs1 | w_op2;
      OP_AND, OP_ANDI:   w_value = RS_reg_rs1 & w_op2;
      OP_SLL, OP_SLLI:   w_value = RS_reg_rs1 << w_op2[4:0];
      OP_SRL, OP_SRLI:   w_value = RS_reg_rs1 >> w_op2[4:0];
      OP_SRA, OP_SRAI:   w_value = $signed(RS_reg_rs1) >>> w_op2[4:0];
      OP_SLT, OP_SLTI:   w_value = {{(DATA_WIDTH-1){1'b0}}, ($signed(RS_reg_rs1) < $signed(w_op2))};
      OP_SLTU, OP_SLTIU: w_value = {{(DATA_WIDTH-1){1'b0}}, (RS_reg_rs1 < w_op2)};
      default: w_value = '0;
    endcase
    if (w_is_br) begin
      w_jump   = w_br_cond;
      w_target = w_br_cond ? w_pcimm : w_pc4;
    end
  end

  logic [ROB_ID_WIDTH-1:0] r_id  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   r_val [FIFO_DEPTH];
  logic                    r_jmp [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   r_tgt [FIFO_DEPTH];
  logic [PW-1:0]           r_head;
  logic [PW-1:0]           r_tail;
  logic [CW-1:0]           r_count;
  logic                    w_nonempty;
  logic                    w_push;
  logic                    w_pop;

  assign w_nonempty = (r_count != '0);
  // A push into a completely full FIFO is dropped rather than overwriting the head.
  assign w_push = RS_input_valid && rdy && !ROB_roll_back_flag && (r_count != CW'(FIFO_DEPTH));
  assign w_pop  = w_nonempty && CDB_grant && rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_id[i]  <= '0;
        r_val[i] <= '0;
        r_jmp[i] <= 1'b0;
        r_tgt[i] <= '0;
      end
    end else if (rdy) begin
      if (ROB_roll_back_flag) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_id[r_tail]  <= RS_ROB_id;
          r_val[r_tail] <= w_value;
          r_jmp[r_tail] <= w_jump;
          r_tgt[r_tail] <= w_target;
          r_tail        <= r_tail + 1'b1;
        end
        if (w_pop) r_head <= r_head + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign RS_ALU_is_full = (r_count >= CW'(FIFO_DEPTH - 1));
  assign CDB_valid      = w_nonempty;
  assign CDB_ROB_id     = w_nonempty ? r_id[r_head]  : '0;
  assign CDB_value      = w_nonempty ? r_val[r_head] : '0;
  assign CDB_jump_flag  = w_nonempty ? r_jmp[r_head] : 1'b0;
  assign CDB_target_pc  = w_nonempty ? r_tgt[r_head] : '0;

`ifdef ALU_PERF_CNT_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_jumps;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_ops   <= '0;
      r_perf_jumps <= '0;
    end else if (w_pop) begin
      r_perf_ops <= r_perf_ops + 32'd1;
      if (r_jmp[r_head]) r_perf_jumps <= r_perf_jumps + 32'd1;
    end
  end

  assign perf_ops_done    = r_perf_ops;
  assign perf_jumps_taken = r_perf_jumps;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: reference model + expected-result queue checked at the CDB head.
// Builds with or without ALU_PERF_CNT_EN.
`timescale 1ns/1ps
module tb_alu_exec_unit;

  localparam int DEPTH = 4;

  localparam logic [5:0] LUI = 6'd1, AUIPC = 6'd2, JAL = 6'd3, JALR = 6'd4;
  localparam logic [5:0] BEQ = 6'd5, BNE = 6'd6, BLT = 6'd7, BGE = 6'd8, BLTU = 6'd9, BGEU = 6'd10;
  localparam logic [5:0] ADDI = 6'd19, SLTI = 6'd20, SLTIU = 6'd21, XORI = 6'd22, ORI = 6'd23;
  localparam logic [5:0] ANDI = 6'd24, SLLI = 6'd25, SRLI = 6'd26, SRAI = 6'd27;
  localparam logic [5:0] ADD = 6'd28, SUB = 6'd29, SLL = 6'd30, SLT = 6'd31, SLTU = 6'd32;
  localparam logic [5:0] XOR_ = 6'd33, SRL = 6'd34, SRA = 6'd35, OR_ = 6'd36, AND_ = 6'd37;

  logic        clk, rst, rdy, ROB_roll_back_flag, RS_input_valid, CDB_grant;
  logic [5:0]  RS_OP_ID;
  logic [31:0] RS_inst_pc, RS_reg_rs1, RS_reg_rs2, RS_imm;
  logic [3:0]  RS_ROB_id;
  logic        RS_ALU_is_full, CDB_valid, CDB_jump_flag;
  logic [3:0]  CDB_ROB_id;
  logic [31:0] CDB_value, CDB_target_pc;
`ifdef ALU_PERF_CNT_EN
  logic [31:0] perf_ops_done, perf_jumps_taken;
`endif

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ROB_roll_back_flag(ROB_roll_back_flag),
    .RS_input_valid(RS_input_valid), .RS_OP_ID(RS_OP_ID), .RS_inst_pc(RS_inst_pc),
    .RS_reg_rs1(RS_reg_rs1), .RS_reg_rs2(RS_reg_rs2), .RS_imm(RS_imm), .RS_ROB_id(RS_ROB_id),
    .RS_ALU_is_full(RS_ALU_is_full), .CDB_grant(CDB_grant), .CDB_valid(CDB_valid),
    .CDB_ROB_id(CDB_ROB_id), .CDB_value(CDB_value), .CDB_jump_flag(CDB_jump_flag),
    .CDB_target_pc(CDB_target_pc)
`ifdef ALU_PERF_CNT_EN
    , .perf_ops_done(perf_ops_done), .perf_jumps_taken(perf_jumps_taken)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [68:0] exp_q[$];  // {rob_id, value, jump, target}

  task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: returns {value, jump, target}.
  function automatic logic [64:0] model(input logic [5:0] op, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] imm);
    logic [31:0] v, t, s, nxt, br;
    logic        j;
    nxt = pc + 32'd4;
    br  = pc + imm;
    s   = (op >= ADDI && op <= SRAI) ? imm : b;
    v = 32'd0; j = 1'b0; t = nxt;
    case (op)
      LUI:         v = imm;
      AUIPC:       v = br;
      JAL:         begin v = nxt; j = 1'b1; t = br; end
      JALR:        begin v = nxt; j = 1'b1; t = (a + imm) & 32'hFFFF_FFFE; end
      BEQ:         j = (a == b);
      BNE:         j = (a != b);
      BLT:         j = ($signed(a) < $signed(b));
      BGE:         j = !($signed(a) < $signed(b));
      BLTU:        j = (a < b);
      BGEU:        j = !(a < b);
      ADD, ADDI:   v = a + s;
      SUB:         v = a - s;
      XOR_, XORI:  v = a ^ s;
      OR_, ORI:    v = a | s;
      AND_, ANDI:  v = a & s;
      SLL, SLLI:   v = a << s[4:0];
      SRL, SRLI:   v = a >> s[4:0];
      SRA, SRAI:   v = 32'($signed(a) >>> s[4:0]);
      SLT, SLTI:   v = ($signed(a) < $signed(s)) ? 32'd1 : 32'd0;
      SLTU, SLTIU: v = (a < s) ? 32'd1 : 32'd0;
      default:     v = 32'd0;
    endcase
    if (op >= BEQ && op <= BGEU) t = j ? br : nxt;
    return {v, j, t};
  endfunction

  // One cycle, entered and left at a negedge. Drives inputs, checks the current outputs against
  // the scoreboard, then updates the scoreboard for what the next posedge does.
  task automatic step(input bit v, input logic [5:0] op, input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm, input logic [3:0] id,
                      input bit g, input bit r, input bit rb,
                      input bit use_f, input logic [64:0] forced);
    int n;
    logic [68:0] e;
    RS_input_valid = v; RS_OP_ID = op; RS_inst_pc = pc; RS_reg_rs1 = a; RS_reg_rs2 = b;
    RS_imm = imm; RS_ROB_id = id; CDB_grant = g; rdy = r; ROB_roll_back_flag = rb;
    #1;
    n = exp_q.size();
    check("cdb_valid", {68'd0, CDB_valid}, {68'd0, n != 0});
    check("is_full", {68'd0, RS_ALU_is_full}, {68'd0, n >= DEPTH - 1});
    if (n == 0)
      check("cdb_idle_zero", {CDB_ROB_id, CDB_value, CDB_jump_flag, CDB_target_pc}, 69'd0);
    else
      check("cdb_head", {CDB_ROB_id, CDB_value, CDB_jump_flag, CDB_target_pc}, exp_q[0]);
    if (r) begin
      if (rb) exp_q.delete();
      else begin
        if (g && n != 0) e = exp_q.pop_front();
        if (v && n < DEPTH) exp_q.push_back({id, use_f ? forced : model(op, pc, a, b, imm)});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit g);
    step(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, g, 1'b1, 1'b0, 1'b0, 65'd0);
  endtask

  task automatic push(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm, input logic [3:0] id,
                      input bit g, input bit use_f, input logic [64:0] f);
    step(1'b1, op, pc, a, b, imm, id, g, 1'b1, 1'b0, use_f, f);
  endtask

  logic [5:0] op_tab [30];

  initial begin
    op_tab = '{LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, ADDI, SLTI, SLTIU, XORI, ORI,
               ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR_, SRL, SRA, OR_, AND_, 6'd50};
    rst = 1'b1; rdy = 1'b1; ROB_roll_back_flag = 1'b0; RS_input_valid = 1'b0; CDB_grant = 1'b0;
    RS_OP_ID = '0; RS_inst_pc = '0; RS_reg_rs1 = '0; RS_reg_rs2 = '0; RS_imm = '0; RS_ROB_id = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", {68'd0, CDB_valid}, 69'd0);
    check("rst_full", {68'd0, RS_ALU_is_full}, 69'd0);
    check("rst_cdb", {CDB_ROB_id, CDB_value, CDB_jump_flag, CDB_target_pc}, 69'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed ops with literal expectations.
    push(ADD, 32'h0, 32'd5, 32'd7, 32'd0, 4'd3, 1'b1, 1'b1, {32'd12, 1'b0, 32'h4});
    idle(1'b1);
    idle(1'b1);
    push(SRAI, 32'h0, 32'hFFFF_FFF8, 32'd0, 32'd1, 4'd4, 1'b1, 1'b1, {32'hFFFF_FFFC, 1'b0, 32'h4});
    push(SLTU, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd5, 1'b1, 1'b1, {32'd0, 1'b0, 32'h4});
    push(BNE, 32'h100, 32'd1, 32'd2, 32'h20, 4'd6, 1'b1, 1'b1, {32'd0, 1'b1, 32'h120});
    push(BEQ, 32'h100, 32'd1, 32'd2, 32'h20, 4'd7, 1'b1, 1'b1, {32'd0, 1'b0, 32'h104});
    push(JALR, 32'h40, 32'h1001, 32'd0, 32'd4, 4'd8, 1'b1, 1'b1, {32'h44, 1'b1, 32'h1004});
    push(6'd63, 32'h200, 32'd9, 32'd9, 32'd9, 4'd9, 1'b1, 1'b1, {32'd0, 1'b0, 32'h204});
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: fill with grant low, then drain in order.
    push(ADD, 32'h0, 32'd1, 32'd0, 32'd0, 4'd1, 1'b0, 1'b0, 65'd0);
    push(ADD, 32'h0, 32'd2, 32'd0, 32'd0, 4'd2, 1'b0, 1'b0, 65'd0);
    push(ADD, 32'h0, 32'd3, 32'd0, 32'd0, 4'd3, 1'b0, 1'b0, 65'd0);
    check("full_at_3", {68'd0, RS_ALU_is_full}, 69'd1);
    repeat (4) idle(1'b1);

    // Overfill: fifth push with grant low is dropped.
    for (int i = 0; i < 5; i++) push(ADDI, 32'h0, 32'd10, 32'd0, 32'(i), 4'(i + 10), 1'b0, 1'b0, 65'd0);
    repeat (5) idle(1'b1);

    // rdy low freezes everything.
    push(LUI, 32'h0, 32'd0, 32'd0, 32'hABCD_E000, 4'd2, 1'b0, 1'b0, 65'd0);
    for (int i = 0; i < 3; i++)
      step(1'b1, ADD, 32'h0, 32'd1, 32'd1, 32'd0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 65'd0);
    idle(1'b1);
    idle(1'b1);

    // Roll back with two entries queued and an op on the input.
    push(JAL, 32'h80, 32'd0, 32'd0, 32'h10, 4'd1, 1'b0, 1'b0, 65'd0);
    push(AUIPC, 32'h80, 32'd0, 32'd0, 32'h1000, 4'd2, 1'b0, 1'b0, 65'd0);
    step(1'b1, ADD, 32'h0, 32'd3, 32'd4, 32'd0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 65'd0);
    idle(1'b0);

    // Async reset mid-stream: outputs clear before any edge.
    push(ORI, 32'h0, 32'hF0, 32'd0, 32'h0F, 4'd4, 1'b0, 1'b0, 65'd0);
    push(XOR_, 32'h0, 32'hF0, 32'hFF, 32'd0, 4'd5, 1'b0, 1'b0, 65'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {68'd0, CDB_valid}, 69'd0);
    check("async_rst_full", {68'd0, RS_ALU_is_full}, 69'd0);
    check("async_rst_cdb", {CDB_ROB_id, CDB_value, CDB_jump_flag, CDB_target_pc}, 69'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a, b, imm, pc;
      bit v, g, r, rb;
      a   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      v   = ($urandom_range(0, 3) != 0) && !(RS_ALU_is_full && $urandom_range(0, 3) != 0);
      g   = ($urandom_range(0, 2) != 0);
      r   = ($urandom_range(0, 9) != 0);
      rb  = ($urandom_range(0, 39) == 0);
      step(v, op_tab[$urandom_range(0, 29)], pc, a, b, imm, 4'($urandom), g, r, rb, 1'b0, 65'd0);
    end
    repeat (6) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
